// File: rtl/ddr_rd_burst_master.sv
// ddr_rd_burst_master: AXI4 read master issuing fixed-length INCR bursts and
// collecting beat/cycle counts, an XOR checksum and a sticky error flag.
module ddr_rd_burst_master #(
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 8,
  parameter int MAX_OUTST = 4,
  parameter int ID_W      = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              RSTART_REG,
  input  logic [31:0]       RADDR_REG,
  input  logic [31:0]       RNBURST_REG,
  output logic              RIDLE_REG,
  output logic [31:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [31:0]       stat_beats,
  output logic [31:0]       stat_cycles,
  output logic [DATA_W-1:0] stat_csum,
  output logic              stat_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int ALIGN = $clog2(BURST_LEN * BYTES);
  localparam logic [31:0] STEP = 32'(BURST_LEN * BYTES);
  localparam logic [31:0] MASK = ~((32'd1 << ALIGN) - 32'd1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;
  logic [1:0] rsync, state;
  logic [31:0] addr;
  logic [15:0] remaining;
  logic [OW-1:0] outstanding;
  logic [8:0] beat_idx;
  logic rst_int_n, start, ar_hs, r_hs, dec, beat_err, unused_hi;
  // Reset asserts asynchronously but is released in step with clk.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rsync <= 2'b00;
    else rsync <= {rsync[0], 1'b1};
  assign rst_int_n = rsync[1];
  assign unused_hi = ^RNBURST_REG[31:16];
  assign start = state == IDLE && RSTART_REG && RNBURST_REG[15:0] != 16'd0;
  assign m_axi_arvalid = state == RUN && remaining != 16'd0 && outstanding < OW'(MAX_OUTST);
  assign m_axi_rready = state != IDLE;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs = m_axi_rvalid & m_axi_rready;
  assign dec = r_hs && m_axi_rlast && outstanding != '0;
  assign beat_err = m_axi_rresp != 2'b00 || m_axi_rlast != (beat_idx == 9'(BURST_LEN - 1)) || outstanding == '0;
  assign RIDLE_REG = state == IDLE;
  assign m_axi_araddr = addr;
  assign m_axi_arlen = 8'(BURST_LEN - 1);
  assign m_axi_arsize = 3'($clog2(BYTES));
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid = '0;
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      outstanding <= '0;
      beat_idx <= '0;
      stat_beats <= '0;
      stat_cycles <= '0;
      stat_csum <= '0;
      stat_err <= 1'b0;
    end else if (start) begin
      state <= RUN;
      addr <= RADDR_REG & MASK;
      remaining <= RNBURST_REG[15:0];
      outstanding <= '0;
      beat_idx <= '0;
      stat_beats <= '0;
      stat_cycles <= '0;
      stat_csum <= '0;
      stat_err <= 1'b0;
    end else if (state != IDLE) begin
      stat_cycles <= stat_cycles + 32'd1;
      outstanding <= outstanding + OW'(ar_hs) - OW'(dec);
      if (ar_hs) begin
        addr <= addr + STEP;
        remaining <= remaining - 16'd1;
      end
      if (r_hs) begin
        stat_beats <= stat_beats + 32'd1;
        stat_csum <= stat_csum ^ m_axi_rdata;
        beat_idx <= m_axi_rlast ? 9'd0 : beat_idx + 9'd1;
        if (beat_err) stat_err <= 1'b1;
      end
      if (state == RUN && ar_hs && remaining == 16'd1) state <= DRAIN;
      else if (state == DRAIN && dec && outstanding == OW'(1)) state <= IDLE;
    end
endmodule

// File: tb/tb_ddr_rd_burst_master.sv
// tb_ddr_rd_burst_master: directed bench with an AXI read slave and a
// transaction-level reference model compared every cycle.
module tb_ddr_rd_burst_master;
  localparam int DATA_W = 64, BURST_LEN = 8, MAX_OUTST = 4, ID_W = 1;
  localparam int BBYTES = BURST_LEN * DATA_W / 8;
  logic clk, rstn, RSTART_REG, RIDLE_REG;
  logic [31:0] RADDR_REG, RNBURST_REG, m_axi_araddr, stat_beats, stat_cycles;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst, m_axi_rresp;
  logic [ID_W-1:0] m_axi_arid;
  logic m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready, stat_err;
  logic [DATA_W-1:0] m_axi_rdata, stat_csum;

  ddr_rd_burst_master #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_OUTST(MAX_OUTST), .ID_W(ID_W)) dut (
    .clk(clk), .rstn(rstn), .RSTART_REG(RSTART_REG), .RADDR_REG(RADDR_REG),
    .RNBURST_REG(RNBURST_REG), .RIDLE_REG(RIDLE_REG), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .stat_beats(stat_beats),
    .stat_cycles(stat_cycles), .stat_csum(stat_csum), .stat_err(stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: command-level bookkeeping of issued/completed bursts
  bit m_idle = 1'b1, m_err = 1'b0, exp_arv, ar_hs, r_hs;
  logic [31:0] m_base = '0, m_beats = '0, m_cycles = '0;
  logic [63:0] m_csum = '0;
  int m_nb = 0, m_iss = 0, m_done = 0, m_bidx = 0, max_out = 0;
  logic [31:0] ar_log[$];
  // read slave state and knobs
  int pend = 0, sb = 0, sg = 0, sbur = 0;
  bit r_hold = 1'b0, csum_mode = 1'b0;
  int err_beat = -1, early_last = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        m_idle = 1'b1; m_err = 1'b0; m_beats = '0; m_cycles = '0; m_csum = '0;
        m_nb = 0; m_iss = 0; m_done = 0; m_bidx = 0;
        pend = 0; sb = 0; sg = 0; sbur = 0;
      end
      exp_arv = !m_idle && m_iss < m_nb && (m_iss - m_done) < MAX_OUTST;
      chk("arvalid", m_axi_arvalid, exp_arv);
      chk("rready", m_axi_rready, !m_idle);
      chk("ridle", RIDLE_REG, m_idle);
      if (exp_arv) chk("araddr", m_axi_araddr, m_base + 32'(m_iss * BBYTES));
      chk("arlen", m_axi_arlen, BURST_LEN - 1);
      chk("arsize_burst_id", {m_axi_arsize, m_axi_arburst, m_axi_arid}, {3'd3, 2'b01, 1'b0});
      chk("stat_beats", stat_beats, m_beats);
      chk("stat_cycles", stat_cycles, m_cycles);
      chk("stat_csum", stat_csum, m_csum);
      chk("stat_err", stat_err, m_err);
      if (rstn) begin
        ar_hs = exp_arv && m_axi_arready;
        r_hs = m_axi_rvalid && !m_idle;
        if (!m_idle) begin
          m_cycles++;
          if (r_hs) begin
            m_beats++;
            m_csum ^= m_axi_rdata;
            if (m_axi_rresp != 2'b00 || m_axi_rlast != (m_bidx == BURST_LEN - 1) || m_iss == m_done) m_err = 1'b1;
            m_bidx = m_axi_rlast ? 0 : m_bidx + 1;
            if (m_axi_rlast && m_iss > m_done) m_done++;
          end
          if (ar_hs) begin
            ar_log.push_back(m_base + 32'(m_iss * BBYTES));
            m_iss++;
          end
          if (m_iss - m_done > max_out) max_out = m_iss - m_done;
          if (m_done == m_nb) m_idle = 1'b1;
        end else if (RSTART_REG && RNBURST_REG[15:0] != 16'd0) begin
          m_idle = 1'b0; m_err = 1'b0; m_beats = '0; m_cycles = '0; m_csum = '0;
          m_base = {RADDR_REG[31:6], 6'd0}; m_nb = int'(RNBURST_REG[15:0]);
          m_iss = 0; m_done = 0; m_bidx = 0; sg = 0; sbur = 0;
        end
        if (ar_hs) pend++;
        if (r_hs) begin
          sg++;
          if (m_axi_rlast) begin pend--; sbur++; sb = 0; end
          else sb++;
        end
      end
      @(posedge clk);
      #1;
      m_axi_rvalid = rstn && !r_hold && pend > 0;
      m_axi_rlast = (early_last >= 0 && sbur == 0 && sb == early_last) || sb == BURST_LEN - 1;
      m_axi_rresp = (sg == err_beat) ? 2'b10 : 2'b00;
      m_axi_rdata = csum_mode ? 64'(sg) : {32'(sg) * 32'h9E3779B9, ~32'(sg)};
    end
  end

  task automatic cmd(input logic [31:0] a, input logic [31:0] n, input bit clr);
    @(posedge clk);
    #1;
    if (clr) ar_log.delete();
    RADDR_REG = a; RNBURST_REG = n; RSTART_REG = 1'b1;
    @(posedge clk);
    #1;
    RSTART_REG = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (!RIDLE_REG && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", RIDLE_REG, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  logic [31:0] nom_addr[4] = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};

  initial begin
    int n;
    rstn = 1'b1; RSTART_REG = 1'b0; RADDR_REG = '0; RNBURST_REG = '0; m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = '0; m_axi_rdata = '0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ridle", RIDLE_REG, 1'b1);
    chk("reset_arvalid", m_axi_arvalid, 1'b0);
    chk("reset_stats", {stat_beats, stat_cycles}, 64'd0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    // nominal
    cmd(32'h1000, 32'd4, 1'b1);
    wait_idle(500);
    chk("nom_ar_count", ar_log.size(), 4);
    for (int i = 0; i < 4; i++) chk("nom_araddr", ar_log.size() > i ? ar_log[i] : 32'hx, nom_addr[i]);
    chk("nom_beats", stat_beats, 32);
    chk("nom_cycles", stat_cycles, 33);
    chk("nom_err", stat_err, 1'b0);
    // backpressure
    r_hold = 1'b1;
    max_out = 0;
    cmd(32'h2000, 32'd10, 1'b1);
    repeat (10) @(negedge clk);
    chk("bp_arvalid_low", m_axi_arvalid, 1'b0);
    chk("bp_ar_count", ar_log.size(), 4);
    r_hold = 1'b0;
    wait_idle(3000);
    chk("bp_beats", stat_beats, 80);
    chk("bp_max_out", max_out, 4);
    chk("bp_ar_total", ar_log.size(), 10);
    // zero-length and busy commands
    cmd(32'h3000, 32'd0, 1'b1);
    repeat (5) @(negedge clk);
    chk("zero_ridle", RIDLE_REG, 1'b1);
    chk("zero_no_ar", ar_log.size(), 0);
    chk("zero_keeps_stats", stat_beats, 80);
    cmd(32'h4000, 32'd2, 1'b1);
    repeat (3) @(negedge clk);
    cmd(32'h5000, 32'd5, 1'b0);
    wait_idle(500);
    chk("busy_beats", stat_beats, 16);
    chk("busy_ar_count", ar_log.size(), 2);
    // error injection
    err_beat = 3;
    cmd(32'h1000, 32'd2, 1'b1);
    wait_idle(500);
    chk("rresp_err", stat_err, 1'b1);
    chk("rresp_beats", stat_beats, 16);
    err_beat = -1;
    early_last = 5;
    cmd(32'h1000, 32'd2, 1'b1);
    wait_idle(500);
    chk("early_last_err", stat_err, 1'b1);
    chk("early_last_beats", stat_beats, 14);
    early_last = -1;
    cmd(32'h1000, 32'd1, 1'b1);
    wait_idle(500);
    chk("good_clears_err", stat_err, 1'b0);
    // checksum and alignment
    csum_mode = 1'b1;
    cmd(32'h1000, 32'd2, 1'b1);
    wait_idle(500);
    chk("csum_zero", stat_csum, 64'd0);
    csum_mode = 1'b0;
    cmd(32'h1023, 32'd1, 1'b1);
    wait_idle(500);
    chk("unaligned_addr", ar_log.size() > 0 ? ar_log[0] : 32'hx, 32'h1000);
    // reset with two bursts outstanding
    r_hold = 1'b1;
    cmd(32'h6000, 32'd2, 1'b1);
    n = 0;
    while (ar_log.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_setup_ars", ar_log.size(), 2);
    #2 rstn = 1'b0;
    #1;
    chk("rst_arvalid", m_axi_arvalid, 1'b0);
    chk("rst_ridle", RIDLE_REG, 1'b1);
    chk("rst_rready", m_axi_rready, 1'b0);
    chk("rst_stats", {stat_beats, stat_cycles}, 64'd0);
    chk("rst_csum_err", {stat_csum[31:0], 31'd0, stat_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    r_hold = 1'b0;
    repeat (5) @(negedge clk);
    cmd(32'h1000, 32'd1, 1'b1);
    wait_idle(500);
    chk("post_reset_beats", stat_beats, 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ddr_rd_burst_master.md
Name: ddr_rd_burst_master

Overview:
AXI4 read master directly downstream of the instruction-driven test controller. It accepts one read command (start pulse, byte address, burst count), issues that many fixed-length INCR bursts to the DDR port, and sinks the returned data. While it works it keeps beat and cycle counters, an XOR checksum and a sticky error flag. RIDLE_REG tells the controller when to fetch its next instruction.

Parameters:
DATA_W, 64, R data width in bits; power of two, at least 8.
BURST_LEN, 8, beats per burst; ARLEN = BURST_LEN-1; range 1..256.
MAX_OUTST, 4, maximum bursts in flight (AR accepted, RLAST not yet received).
ID_W, 1, ARID width; ARID is constant 0.

Ports:
clk  in  1  single clock domain.
rstn  in  1  asynchronous active-low reset.
RSTART_REG  in  1  one-cycle command start pulse.
RADDR_REG  in  32  start byte address.
RNBURST_REG  in  32  number of bursts; only bits [15:0] are used.
RIDLE_REG  out  1  high when no command is active.
m_axi_araddr  out  32  burst address.
m_axi_arlen  out  8  constant BURST_LEN-1.
m_axi_arsize  out  3  constant log2(DATA_W/8).
m_axi_arburst  out  2  constant 2'b01 (INCR).
m_axi_arid  out  ID_W  constant 0.
m_axi_arvalid  out  1  AR valid.
m_axi_arready  in  1  AR ready.
m_axi_rdata  in  DATA_W  read data.
m_axi_rresp  in  2  read response.
m_axi_rlast  in  1  last beat of a burst.
m_axi_rvalid  in  1  R valid.
m_axi_rready  out  1  R ready.
stat_beats  out  32  R beats accepted for the current command.
stat_cycles  out  32  cycles from command accept to RIDLE rise.
stat_csum  out  DATA_W  XOR of all accepted rdata.
stat_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync deassert inside block): state IDLE; RIDLE_REG=1; arvalid=0; rready=0; all stat_* = 0; all internal counters = 0.
- A reset during an active command aborts it immediately. The interconnect must be reset together with this block.
- FSM states are IDLE, RUN, DRAIN.
- IDLE:
  - RSTART_REG=1 and RNBURST_REG[15:0]!=0: go to RUN; RIDLE_REG falls on this same edge; latch addr = {RADDR_REG[31:6-aligned], zeros}; remaining = RNBURST_REG[15:0]; clear stat_beats, stat_cycles, stat_csum, stat_err.
  - Address alignment: the low log2(BURST_LEN*DATA_W/8) address bits are forced to 0, so bursts never cross 4 KB.
  - RSTART_REG=1 with RNBURST_REG[15:0]=0: no-op; RIDLE_REG stays 1; stats are not cleared.
- RSTART_REG is ignored in RUN and DRAIN.
- RUN:
  - arvalid=1 while remaining>0 and outstanding<MAX_OUTST.
  - araddr holds stable until the handshake. On arvalid&arready: araddr += BURST_LEN*DATA_W/8, remaining -= 1, outstanding += 1.
  - When remaining reaches 0: go to DRAIN.
- rready=1 in RUN and DRAIN; rready=0 in IDLE.
- On each rvalid&rready:
  - stat_beats += 1; stat_csum ^= rdata; beat_idx += 1.
  - On rlast: outstanding -= 1 and beat_idx = 0.
- Outstanding counter: an AR handshake and an rlast handshake in the same cycle leave outstanding unchanged.
- stat_err is set (sticky until the next command accept) on any of:
  - rresp != 0;
  - rlast=1 with beat_idx != BURST_LEN-1;
  - rlast=0 with beat_idx == BURST_LEN-1;
  - an R beat arriving while outstanding == 0.
- DRAIN: when an rlast handshake brings outstanding to 0, go to IDLE; RIDLE_REG rises on that edge.
- stat_cycles counts +1 every cycle in RUN or DRAIN, including the final handshake cycle, and holds in IDLE.
- Counters wrap modulo 2^32 with no saturation.

Test Plan:
- Nominal: RADDR=0x1000, RNBURST=4, arready=1, slave with 1-cycle R latency → 4 ARs at 0x1000/0x1040/0x1080/0x10C0 with arlen=7; stat_beats=32; RIDLE rises after the 4th rlast; stat_err=0.
- Backpressure: MAX_OUTST=4, RNBURST=10, slave withholds R data → arvalid drops after the 4th AR and resumes as each rlast returns; outstanding never exceeds 4; stat_beats=80.
- Zero and busy commands: RNBURST=0 → RIDLE stays 1, no AR issued. A second RSTART pulse mid-run → ignored; beat count is unchanged.
- Errors: one beat with rresp=2'b10 → stat_err=1 while the command still completes. Early rlast on beat 5 → stat_err=1. A subsequent good command clears stat_err.
- Checksum: rdata = beat index 0..15 over RNBURST=2 → stat_csum=0. Unaligned RADDR=0x1023 → first araddr=0x1000.
- Reset mid-RUN: assert rstn=0 with 2 bursts outstanding → arvalid=0, RIDLE_REG=1, stats=0 asynchronously.
